// File: rtl/tap_rec.sv
`default_nettype none
//==============================================================================
// Module   : tap_rec
// Purpose  : Decodes MIC pulse trains (pilot/sync/data) into bytes and stores
//            them as .TAP blocks. Macro TAPREC_CHECKSUM_EN adds the XOR flag.
// Revision : 1.0  initial release
//==============================================================================
module tap_rec #(
   parameter int          PILOT_LO    = 1939,
   parameter int          PILOT_HI    = 2600,
   parameter int          PILOT_COUNT = 256,
   parameter int          SYNC_MAX    = 800,
   parameter int          BIT_THR     = 2565,
   parameter int          GAP_TICKS   = 3500,
   parameter logic [16:0] MEM_TOP     = 17'h1FFFF
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        ce,
   input  logic        arm,
   input  logic        mic_in,
   output logic [16:0] wr_address,
   output logic [7:0]  wr_data,
   output logic        wr_we,
   output logic        busy,
   output logic [7:0]  blocks,
   output logic [16:0] end_address,
   output logic        overflow,
   output logic        chk_err
);

   localparam logic [11:0] c_pilot_lo   = 12'(PILOT_LO);
   localparam logic [11:0] c_pilot_hi   = 12'(PILOT_HI);
   localparam logic [15:0] c_pilot_last = 16'(PILOT_COUNT - 1);
   localparam logic [11:0] c_sync_max   = 12'(SYNC_MAX);
   localparam logic [12:0] c_bit_thr    = 13'(BIT_THR);
   localparam logic [11:0] c_gap        = 12'(GAP_TICKS);
   localparam logic [17:0] c_mem_top    = {1'b0, MEM_TOP};

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_PILOT  = 3'd1,
      S_SYNC2  = 3'd2,
      S_DATA   = 3'd3,
      S_LEN_LO = 3'd4,
      S_LEN_HI = 3'd5
   } state_t;

   state_t      r_state, w_next;
   logic        r_sync1, r_sync2, r_level, r_arm_d;
   logic [11:0] r_halfcnt, r_first;
   logic [15:0] r_pcnt, r_len;
   logic        r_second;
   logic [6:0]  r_shift;
   logic [2:0]  r_bitcnt;
   logic [17:0] r_ptr, r_base;
   logic [16:0] r_end, r_wr_addr;
   logic [7:0]  r_blocks, r_wr_data;
   logic        r_ovf, r_blk_ovf, r_we;

   logic        w_edge, w_timeout, w_is_pilot, w_is_sync, w_bit, w_arm_rise;
   logic [12:0] w_period;
   logic        w_start, w_byte_done, w_commit, w_req, w_wr_ok;
   logic [17:0] w_addr;
   logic [7:0]  w_data;

   assign w_edge     = ce & (r_sync2 ^ r_level);
   assign w_timeout  = (r_state != S_IDLE) && !w_edge && (r_halfcnt == c_gap);
   assign w_is_pilot = (r_halfcnt >= c_pilot_lo) && (r_halfcnt <= c_pilot_hi);
   assign w_is_sync  = (r_halfcnt < c_sync_max);
   assign w_period   = {1'b0, r_first} + {1'b0, r_halfcnt};
   assign w_bit      = (w_period >= c_bit_thr);
   assign w_arm_rise = arm & ~r_arm_d;
   assign w_wr_ok    = w_req && (w_addr <= c_mem_top);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next      = r_state;
      w_start     = 1'b0;
      w_byte_done = 1'b0;
      w_commit    = 1'b0;
      w_req       = 1'b0;
      w_addr      = r_ptr;
      w_data      = {r_shift, w_bit};
      case (r_state)
         S_IDLE: begin
            if (w_edge && w_is_pilot && (r_pcnt == c_pilot_last)) w_next = S_PILOT;
         end
         S_PILOT: begin
            if (w_edge) begin
               if (w_is_pilot)     w_next = S_PILOT;
               else if (w_is_sync) w_next = S_SYNC2;
               else                w_next = S_IDLE;
            end else if (w_timeout) begin
               w_next = S_IDLE;
            end
         end
         S_SYNC2: begin
            if (w_edge) begin
               if (w_is_sync) begin
                  w_next  = S_DATA;
                  w_start = 1'b1;
               end else begin
                  w_next = S_IDLE;
               end
            end else if (w_timeout) begin
               w_next = S_IDLE;
            end
         end
         S_DATA: begin
            if (w_edge) begin
               if (r_second && (r_bitcnt == 3'd7)) begin
                  w_byte_done = 1'b1;
                  w_req       = 1'b1;
               end
            end else if (w_timeout) begin
               w_next = S_LEN_LO;
            end
         end
         S_LEN_LO: begin
            if (r_len == 16'd0) begin
               w_next = S_IDLE;
            end else begin
               w_req  = 1'b1;
               w_addr = r_base;
               w_data = r_len[7:0];
               w_next = S_LEN_HI;
            end
         end
         S_LEN_HI: begin
            w_req    = 1'b1;
            w_addr   = r_base + 18'd1;
            w_data   = r_len[15:8];
            w_commit = 1'b1;
            w_next   = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
      // Disarming drops whatever block is in flight.
      if (!arm) begin
         w_next      = S_IDLE;
         w_start     = 1'b0;
         w_byte_done = 1'b0;
         w_commit    = 1'b0;
         w_req       = 1'b0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_sync1 <= 1'b0;  r_sync2 <= 1'b0;  r_level <= 1'b0;  r_arm_d <= 1'b0;
         r_halfcnt <= '0;  r_first <= '0;    r_pcnt <= '0;     r_len <= '0;
         r_second <= 1'b0; r_shift <= '0;    r_bitcnt <= '0;
         r_ptr <= '0;      r_base <= '0;     r_end <= '0;      r_blocks <= '0;
         r_ovf <= 1'b0;    r_blk_ovf <= 1'b0;
         r_we <= 1'b0;     r_wr_addr <= '0;  r_wr_data <= '0;
      end else begin
         r_sync1 <= mic_in;
         r_sync2 <= r_sync1;
         r_arm_d <= arm;
         if (ce) begin
            r_level <= r_sync2;
            if (w_edge)                   r_halfcnt <= 12'd1;
            else if (r_halfcnt != 12'hFFF) r_halfcnt <= r_halfcnt + 12'd1;
         end
         if ((r_state != S_IDLE) || !arm) r_pcnt <= 16'd0;
         else if (w_edge)                 r_pcnt <= w_is_pilot ? r_pcnt + 16'd1 : 16'd0;
         if (w_start) begin
            r_base    <= {1'b0, r_end};
            r_ptr     <= {1'b0, r_end} + 18'd2;
            r_len     <= 16'd0;
            r_bitcnt  <= 3'd0;
            r_second  <= 1'b0;
            r_blk_ovf <= 1'b0;
         end else if ((r_state == S_DATA) && w_edge) begin
            if (!r_second) begin
               r_first  <= r_halfcnt;
               r_second <= 1'b1;
            end else begin
               r_second <= 1'b0;
               r_shift  <= {r_shift[5:0], w_bit};
               r_bitcnt <= r_bitcnt + 3'd1;
               if (w_byte_done) begin
                  r_ptr <= r_ptr + 18'd1;
                  r_len <= r_len + 16'd1;
               end
            end
         end
         r_we <= w_wr_ok;
         if (w_req) begin
            r_wr_addr <= w_addr[16:0];
            r_wr_data <= w_data;
         end
         if (w_req && !w_wr_ok) begin
            r_ovf     <= 1'b1;
            r_blk_ovf <= 1'b1;
         end
         if (w_commit && !r_blk_ovf && w_wr_ok) begin
            r_end    <= r_ptr[16:0];
            r_blocks <= r_blocks + 8'd1;
         end
         if (w_arm_rise) begin
            r_end    <= 17'd0;
            r_blocks <= 8'd0;
            r_ovf    <= 1'b0;
         end
      end
   end

`ifdef TAPREC_CHECKSUM_EN
   logic [7:0] r_xor;
   logic       r_chk;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_xor <= 8'd0;
         r_chk <= 1'b0;
      end else begin
         if (w_start)          r_xor <= 8'd0;
         else if (w_byte_done) r_xor <= r_xor ^ w_data;
         if (w_arm_rise)       r_chk <= 1'b0;
         else if (w_commit)    r_chk <= (r_xor != 8'd0);
      end
   end
   assign chk_err = r_chk;
`else
   assign chk_err = 1'b0;
`endif

   assign wr_address  = r_wr_addr;
   assign wr_data     = r_wr_data;
   assign wr_we       = r_we;
   assign busy        = (r_state != S_IDLE);
   assign blocks      = r_blocks;
   assign end_address = r_end;
   assign overflow    = r_ovf;

endmodule
`default_nettype wire
